// File: rtl/arith_seq_if.sv
// Handshake and control bundle between the arith_seq sequencer and its external shift/add datapath.
// The sequencer takes the slave modport; the datapath or testbench side takes the master modport.
interface arith_seq_if;
    logic START;
    logic OP;
    logic MBIT;
    logic BORROW;
    logic BZERO;
    logic OPR_LD;
    logic OPR_SH;
    logic ACC_CLR;
    logic ACC_SH;
    logic ACC_WR;
    logic Q_SH;
    logic SERQ;
    logic BUSY;
    logic DONE;
    logic ERR;

    modport master (
        output START, OP, MBIT, BORROW, BZERO,
        input  OPR_LD, OPR_SH, ACC_CLR, ACC_SH, ACC_WR, Q_SH, SERQ, BUSY, DONE, ERR
    );

    modport slave (
        input  START, OP, MBIT, BORROW, BZERO,
        output OPR_LD, OPR_SH, ACC_CLR, ACC_SH, ACC_WR, Q_SH, SERQ, BUSY, DONE, ERR
    );
endinterface

// File: rtl/arith_seq.sv
// arith_seq: control sequencer for an N-bit shift-add multiplier / restoring divider datapath.
// Divide is compiled in only when ARITH_SEQ_DIV_EN is defined; otherwise OP=1 finishes with ERR.
module arith_seq #(
    parameter int N = 8
) (
    input logic        CLK,
    input logic        RSTn,
    arith_seq_if.slave bus
);
    localparam int CW = $clog2(N + 1);

`ifdef ARITH_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, EXEC, FIN} state_t;

    // Registered Moore strobes; exec qualifies the two Mealy outputs driven from the datapath flags.
    typedef struct packed {
        logic opr_ld;
        logic acc_clr;
        logic acc_sh;
        logic opr_sh;
        logic q_sh;
        logic exec;
        logic busy;
        logic done;
        logic err;
    } ctl_t;

    function automatic ctl_t decode(input state_t s, input logic div, input logic err);
        ctl_t c;
        c      = '0;
        c.busy = (s != IDLE);
        case (s)
            LOAD: begin
                c.opr_ld  = 1'b1;
                c.acc_clr = 1'b1;
            end
            SHIFT: c.acc_sh = 1'b1;
            EXEC: begin
                c.exec   = 1'b1;
                c.opr_sh = 1'b1;
                c.q_sh   = div;
            end
            FIN: begin
                c.done = 1'b1;
                c.err  = err;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_q;
    logic          bzero_q;
    ctl_t          ctl;

    logic div_op;
    logic bad_op;

    assign div_op = op_q & DIV_EN;
    assign bad_op = op_q & (~DIV_EN | bzero_q);

    // NOTE: outputs are registered from the destination state, so every strobe changes
    // exactly at the edge that enters its state, and all state updates use <=.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= 1'b0;
            bzero_q <= 1'b0;
            ctl     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        state   <= LOAD;
                        op_q    <= bus.OP;
                        bzero_q <= bus.BZERO & DIV_EN;
                        cnt     <= CW'(N);
                        ctl     <= decode(LOAD, 1'b0, 1'b0);
                    end
                end
                LOAD: begin
                    if (bad_op) begin
                        state <= FIN;
                        ctl   <= decode(FIN, 1'b0, 1'b1);
                    end else begin
                        state <= SHIFT;
                        ctl   <= decode(SHIFT, 1'b0, 1'b0);
                    end
                end
                SHIFT: begin
                    state <= EXEC;
                    ctl   <= decode(EXEC, div_op, 1'b0);
                end
                EXEC: begin
                    // Saturating count: the last iteration parks the counter at zero.
                    if (cnt <= CW'(1)) begin
                        cnt   <= '0;
                        state <= FIN;
                        ctl   <= decode(FIN, 1'b0, 1'b0);
                    end else begin
                        cnt   <= cnt - CW'(1);
                        state <= SHIFT;
                        ctl   <= decode(SHIFT, 1'b0, 1'b0);
                    end
                end
                FIN: begin
                    state <= IDLE;
                    ctl   <= decode(IDLE, 1'b0, 1'b0);
                end
                default: begin
                    state <= IDLE;
                    ctl   <= '0;
                end
            endcase
        end
    end

    assign bus.OPR_LD  = ctl.opr_ld;
    assign bus.ACC_CLR = ctl.acc_clr;
    assign bus.ACC_SH  = ctl.acc_sh;
    assign bus.OPR_SH  = ctl.opr_sh;
    assign bus.Q_SH    = ctl.q_sh;
    assign bus.BUSY    = ctl.busy;
    assign bus.DONE    = ctl.done;
    assign bus.ERR     = ctl.err;

    // NOTE: ACC_WR and SERQ follow MBIT/BORROW combinationally within EXEC; gating by the
    // reset-cleared exec bit keeps them low while RSTn is asserted.
    assign bus.ACC_WR = ctl.exec & (op_q ? (DIV_EN & ~bus.BORROW) : bus.MBIT);
    assign bus.SERQ   = ctl.exec & op_q & DIV_EN & ~bus.BORROW;

    a_no_sh_wr: assert property (@(posedge CLK) disable iff (!RSTn) !(bus.ACC_SH && bus.ACC_WR));
    a_done_pulse: assert property (@(posedge CLK) disable iff (!RSTn) bus.DONE |=> !bus.DONE);
    a_idle_quiet: assert property (@(posedge CLK) disable iff (!RSTn)
        !bus.BUSY |-> !(bus.OPR_LD || bus.ACC_CLR || bus.ACC_SH || bus.ACC_WR || bus.Q_SH));
endmodule

// File: tb/tb_arith_seq.sv
// Directed bench for arith_seq with a behavioural shift-add / restoring-divide datapath model.
// Divide expectations follow ARITH_SEQ_DIV_EN; without it OP=1 must end in ERR after two cycles.
module tb_arith_seq;
    localparam int N = 8;

    logic CLK;
    logic RSTn;

    arith_seq_if bus ();

    arith_seq #(.N(N)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic           dp_div;
    logic [N-1:0]   opr;
    logic [N-1:0]   opb;
    logic [N-1:0]   quo;
    logic [2*N-1:0] acc;
    logic [9:0]     all_outs;
    bit             overlap = 1'b0;

    assign all_outs = {bus.OPR_LD, bus.OPR_SH, bus.ACC_CLR, bus.ACC_SH, bus.ACC_WR,
                       bus.Q_SH, bus.SERQ, bus.BUSY, bus.DONE, bus.ERR};

    // Datapath model: multiplier/dividend in opr, multiplicand/divisor in opb.
    assign bus.MBIT   = opr[N-1];
    assign bus.BORROW = (acc < {{N{1'b0}}, opb});

    always @(posedge CLK) begin
        if (bus.OPR_LD) begin
            opr <= a_in;
            opb <= b_in;
        end else if (bus.OPR_SH) begin
            opr <= opr << 1;
        end
        if (bus.ACC_CLR) begin
            acc <= '0;
            quo <= '0;
        end else if (bus.ACC_SH) begin
            acc <= {acc[2*N-2:0], dp_div & opr[N-1]};
        end else if (bus.ACC_WR) begin
            acc <= dp_div ? acc - {{N{1'b0}}, opb} : acc + {{N{1'b0}}, opb};
        end
        if (bus.Q_SH) quo <= {quo[N-2:0], bus.SERQ};
    end

    always @(negedge CLK) begin
        if (bus.ACC_SH && bus.ACC_WR) overlap <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operation and measure it; cycle 1 is the cycle after the accepting edge.
    task automatic run_op(input string tag, input bit op, input bit bz,
                          input logic [N-1:0] a, input logic [N-1:0] b, input bit wiggle,
                          input int exp_cyc, input bit exp_err, input int exp_sh, input int exp_qsh);
        int cyc;
        bit seen;
        bit err_seen;
        int n_accsh;
        int n_oprsh;
        int n_qsh;
        @(negedge CLK);
        a_in      = a;
        b_in      = b;
        dp_div    = op;
        bus.OP    = op;
        bus.BZERO = bz;
        bus.START = 1'b1;
        check({tag, "_idle_before"}, 32'(bus.BUSY), 0);
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
        if (wiggle) begin
            bus.OP    = ~op;
            bus.BZERO = ~bz;
        end
        check({tag, "_load"}, 32'({bus.OPR_LD, bus.ACC_CLR, bus.BUSY}), 32'd7);
        cyc      = 1;
        seen     = 1'b0;
        err_seen = 1'b0;
        n_accsh  = 0;
        n_oprsh  = 0;
        n_qsh    = 0;
        while (!seen && cyc < 60) begin
            if (bus.ACC_SH) n_accsh++;
            if (bus.OPR_SH) n_oprsh++;
            if (bus.Q_SH)   n_qsh++;
            if (bus.DONE) begin
                seen     = 1'b1;
                err_seen = bus.ERR;
            end else begin
                @(negedge CLK);
                cyc++;
            end
        end
        check({tag, "_done_cycle"}, 32'(seen ? cyc : 0), 32'(exp_cyc));
        check({tag, "_err"}, 32'(err_seen), 32'(exp_err));
        check({tag, "_acc_sh"}, 32'(n_accsh), 32'(exp_sh));
        check({tag, "_opr_sh"}, 32'(n_oprsh), 32'(exp_sh));
        check({tag, "_q_sh"}, 32'(n_qsh), 32'(exp_qsh));
        @(negedge CLK);
        check({tag, "_idle_after"}, 32'({bus.BUSY, bus.DONE}), 0);
        bus.OP    = 1'b0;
        bus.BZERO = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cyc [3];
        int sh_cnt [3];
        int n_done;
        int busy19;
        int busy38;
        int guard;
        int n_exec;
        bit drained;

        RSTn      = 1'b0;
        bus.START = 1'b0;
        bus.OP    = 1'b0;
        bus.BZERO = 1'b0;
        a_in      = '0;
        b_in      = '0;
        dp_div    = 1'b0;

        // Reset state, with START requested during reset.
        repeat (2) @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        check("reset_outputs", 32'(all_outs), 0);
        bus.START = 1'b0;
        RSTn = 1'b1;
        @(negedge CLK);
        check("idle_after_reset", 32'(all_outs), 0);

        run_op("mul13x11", 1'b0, 1'b0, 8'd13, 8'd11, 1'b0, 18, 1'b0, 8, 0);
        check("mul13x11_product", 32'(acc), 143);

`ifdef ARITH_SEQ_DIV_EN
        run_op("div200_7", 1'b1, 1'b0, 8'd200, 8'd7, 1'b0, 18, 1'b0, 8, 8);
        check("div200_7_quotient", 32'(quo), 28);
        check("div200_7_remainder", 32'(acc), 4);
`else
        run_op("div_disabled", 1'b1, 1'b0, 8'd200, 8'd7, 1'b0, 2, 1'b1, 0, 0);
`endif

        run_op("div_by_zero", 1'b1, 1'b1, 8'd200, 8'd0, 1'b0, 2, 1'b1, 0, 0);

        // OP and BZERO flip right after capture and must be ignored.
        run_op("mul255x255", 1'b0, 1'b0, 8'd255, 8'd255, 1'b1, 18, 1'b0, 8, 0);
        check("mul255x255_product", 32'(acc), 65025);

        // START held high for 40 cycles: back-to-back operations 19 cycles apart.
        @(negedge CLK);
        a_in      = 8'd13;
        b_in      = 8'd11;
        dp_div    = 1'b0;
        bus.START = 1'b1;
        @(posedge CLK);
        n_done = 0;
        busy19 = 1;
        busy38 = 1;
        for (int i = 0; i < 3; i++) begin
            done_cyc[i] = 0;
            sh_cnt[i]   = 0;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (bus.ACC_SH && n_done < 3) sh_cnt[n_done]++;
            if (bus.DONE && n_done < 3) begin
                done_cyc[n_done] = c;
                n_done++;
            end
            if (c == 19) busy19 = 32'(bus.BUSY);
            if (c == 38) busy38 = 32'(bus.BUSY);
        end
        bus.START = 1'b0;
        check("hold_done_count", 32'(n_done), 2);
        check("hold_first_done", 32'(done_cyc[0]), 18);
        check("hold_second_done", 32'(done_cyc[1]), 37);
        check("hold_first_acc_sh", 32'(sh_cnt[0]), 8);
        check("hold_second_acc_sh", 32'(sh_cnt[1]), 8);
        check("hold_idle_c19", 32'(busy19), 0);
        check("hold_idle_c38", 32'(busy38), 0);
        drained = 1'b0;
        for (int c = 0; c < 40 && !drained; c++) begin
            @(negedge CLK);
            if (bus.DONE) drained = 1'b1;
        end
        check("hold_third_done", 32'(drained), 1);
        check("hold_third_product", 32'(acc), 143);
        @(negedge CLK);
        check("hold_idle_end", 32'(bus.BUSY), 0);

        // Reset asserted mid-cycle during the third EXEC cycle.
        @(negedge CLK);
        a_in      = 8'd13;
        b_in      = 8'd11;
        dp_div    = 1'b0;
        bus.START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
        n_exec = 0;
        guard  = 0;
        if (bus.OPR_SH) n_exec++;
        while (n_exec < 3 && guard < 20) begin
            @(negedge CLK);
            guard++;
            if (bus.OPR_SH) n_exec++;
        end
        check("abort_third_exec_found", 32'(n_exec), 3);
        #2 RSTn = 1'b0;
        #1 check("abort_async_outputs", 32'(all_outs), 0);
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        n_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge CLK);
            if (bus.DONE || bus.BUSY) n_done++;
        end
        check("abort_no_done", 32'(n_done), 0);

        run_op("mul_after_abort", 1'b0, 1'b0, 8'd13, 8'd11, 1'b0, 18, 1'b0, 8, 0);
        check("mul_after_abort_product", 32'(acc), 143);

        check("no_acc_sh_wr_overlap", 32'(overlap), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
